// File: rtl/anita4_trig_pkg.sv
// Shared types and limits for the ANITA4 single-output trigger transmitter.
package anita4_trig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } trig_state_t;

    localparam int CNT_W  = 16;
    localparam int TMR_W  = 8;
    localparam int PW_MIN = 1;
    localparam int PW_MAX = 255;
    localparam int HO_MIN = 0;
    localparam int HO_MAX = 255;

    function automatic int clamp(input int val, input int lo, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

endpackage

// File: rtl/anita4_sat_counter.sv
// Event counter with synchronous clear; SATURATE selects stick-at-max or wrap.
module anita4_sat_counter
    import anita4_trig_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             CLR,
    input  logic             INC,
    output logic [CNT_W-1:0] COUNT
);

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            COUNT <= '0;
        end else if (CLR) begin
            COUNT <= '0;
        end else if (INC && !(SATURATE && (&COUNT))) begin
            COUNT <= COUNT + CNT_W'(1);
        end
    end

endmodule

// File: rtl/anita4_trig_single_tx.sv
// Single trigger transmitter: fixed-width pulse, holdoff window, accept/drop counters.
// Optional retrigger queueing during holdoff: define ANITA4_TRIG_TX_RETRIG_EN.
module anita4_trig_single_tx
    import anita4_trig_pkg::*;
#(
    parameter int PULSE_WIDTH = 4,
    parameter int HOLDOFF     = 8
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             TRIG_REQ,
    input  logic             MASK,
    input  logic             FORCE,
    input  logic             CLR_COUNTS,
    output logic             TRIG_OUT,
    output logic             BUSY,
    output logic [CNT_W-1:0] PULSE_COUNT,
    output logic [CNT_W-1:0] DROP_COUNT,
    output trig_state_t      STATE_DBG
);

    localparam int PW_EFF = clamp(PULSE_WIDTH, PW_MIN, PW_MAX);
    localparam int HO_EFF = clamp(HOLDOFF, HO_MIN, HO_MAX);
    localparam logic [TMR_W-1:0] PW_LOAD = TMR_W'(PW_EFF - 1);
    localparam logic [TMR_W-1:0] HO_LOAD = TMR_W'(HO_EFF - 1);

    trig_state_t      state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rst_sync_q;
    logic             run, req, launch, accept, drop;

    // Reset asserts asynchronously but releases two clocks later.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign run = rst_sync_q[1];
    assign req = FORCE | (TRIG_REQ & ~MASK);

`ifdef ANITA4_TRIG_TX_RETRIG_EN
    logic pend_q, pend_d;
    assign launch = req | pend_q;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) pend_q <= 1'b0;
        else        pend_q <= pend_d;
    end
`else
    assign launch = req;
`endif

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            TRIG_OUT <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            TRIG_OUT <= (state_q == PULSE);
            BUSY     <= (state_q != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        drop    = 1'b0;
`ifdef ANITA4_TRIG_TX_RETRIG_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (run && launch) begin
                    state_d = PULSE;
                    cnt_d   = PW_LOAD;
                    accept  = 1'b1;
`ifdef ANITA4_TRIG_TX_RETRIG_EN
                    pend_d  = 1'b0;
`endif
                end
            end
            PULSE: begin
                drop = req;
                if (cnt_q == '0) begin
                    if (HO_EFF > 0) begin
                        state_d = HOLD;
                        cnt_d   = HO_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - TMR_W'(1);
                end
            end
            HOLD: begin
`ifdef ANITA4_TRIG_TX_RETRIG_EN
                // Only the first holdoff request is queued; later ones are drops.
                if (req) begin
                    if (pend_q) drop = 1'b1;
                    else        pend_d = 1'b1;
                end
`else
                drop = req;
`endif
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d = cnt_q - TMR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    anita4_sat_counter #(.SATURATE(1'b0)) u_pulse_cnt (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .CLR   (CLR_COUNTS),
        .INC   (accept),
        .COUNT (PULSE_COUNT)
    );

    anita4_sat_counter #(.SATURATE(1'b1)) u_drop_cnt (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .CLR   (CLR_COUNTS),
        .INC   (drop),
        .COUNT (DROP_COUNT)
    );

    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_anita4_trig_single_tx.sv
// Directed bench for anita4_trig_single_tx: default instance plus a PULSE_WIDTH=1/HOLDOFF=0 instance.
module tb_anita4_trig_single_tx;
  import anita4_trig_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  logic trig_req, mask, force_req, clr_counts;
  logic trig_out, busy;
  logic [15:0] pulse_count, drop_count;
  trig_state_t state_dbg;

  logic r2_req, r2_mask, r2_force, r2_clr;
  logic r2_trig, r2_busy;
  logic [15:0] r2_pulse, r2_drop;
  trig_state_t r2_state;

  anita4_trig_single_tx #(.PULSE_WIDTH(4), .HOLDOFF(8)) dut (
    .CLK(clk), .CLR_N(clr_n), .TRIG_REQ(trig_req), .MASK(mask), .FORCE(force_req),
    .CLR_COUNTS(clr_counts), .TRIG_OUT(trig_out), .BUSY(busy),
    .PULSE_COUNT(pulse_count), .DROP_COUNT(drop_count), .STATE_DBG(state_dbg)
  );

  anita4_trig_single_tx #(.PULSE_WIDTH(1), .HOLDOFF(0)) dut2 (
    .CLK(clk), .CLR_N(clr_n), .TRIG_REQ(r2_req), .MASK(r2_mask), .FORCE(r2_force),
    .CLR_COUNTS(r2_clr), .TRIG_OUT(r2_trig), .BUSY(r2_busy),
    .PULSE_COUNT(r2_pulse), .DROP_COUNT(r2_drop), .STATE_DBG(r2_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    clr_n = 1'b0;
    step(2);
    clr_n = 1'b1;
  endtask

  task automatic pulse_req();
    trig_req = 1'b1;
    step(1);
    trig_req = 1'b0;
  endtask

  task automatic drain_q(input string tag);
    while (exp_q.size() > 0) begin
      step(1);
      check(tag, {trig_out, busy}, exp_q.pop_front());
    end
  endtask

  initial begin
    trig_req = 0; mask = 0; force_req = 0; clr_counts = 0;
    r2_req = 0; r2_mask = 0; r2_force = 0; r2_clr = 0;
    #2;

    // asynchronous reset values, no clock edge needed
    clr_n = 1'b0;
    #1;
    check("rst_trig", trig_out, 0);
    check("rst_busy", busy, 0);
    check("rst_pcnt", pulse_count, 0);
    check("rst_dcnt", drop_count, 0);
    check("rst_state", state_dbg, IDLE);
    check("rst_r2_trig", r2_trig, 0);
    step(2);
    clr_n = 1'b1;

    // requests on edges 1-2 fall inside the release synchroniser
    trig_req = 1'b1;
    step(2);
    trig_req = 1'b0;
    step(2);
    check("sync_trig", trig_out, 0);
    check("sync_busy", busy, 0);
    check("sync_pcnt", pulse_count, 0);

    // request at edge 10: TRIG_OUT 11-14, BUSY 11-22
    apply_reset();
    step(9);
    pulse_req();
    check("t1_trig_e10", trig_out, 0);
    check("t1_pcnt_e10", pulse_count, 1);
    for (int e = 11; e <= 24; e++)
      exp_q.push_back({(e >= 11 && e <= 14), (e >= 11 && e <= 22)});
    drain_q("t1_trig_busy");
    check("t1_pcnt", pulse_count, 1);
    check("t1_dcnt", drop_count, 0);

    // request during holdoff
    apply_reset();
    step(9);
    pulse_req();
    step(5);
    pulse_req();
`ifdef ANITA4_TRIG_TX_RETRIG_EN
    pulse_req();
    step(5);
    check("rt_pcnt_e22", pulse_count, 1);
    check("rt_dcnt_e22", drop_count, 1);
    step(1);
    check("rt_pcnt_e23", pulse_count, 2);
    check("rt_dcnt_e23", drop_count, 1);
    check("rt_trig_e23", trig_out, 0);
    step(1);
    check("rt_trig_e24", trig_out, 1);
`else
    step(6);
    check("ho_pcnt_e22", pulse_count, 1);
    check("ho_dcnt_e22", drop_count, 1);
    pulse_req();
    check("ho_pcnt_e23", pulse_count, 2);
    check("ho_dcnt_e23", drop_count, 1);
    step(1);
    check("ho_trig_e24", trig_out, 1);
`endif

    // MASK gates TRIG_REQ but not FORCE
    apply_reset();
    step(9);
    mask = 1'b1;
    pulse_req();
    step(4);
    check("mask_trig", trig_out, 0);
    check("mask_busy", busy, 0);
    check("mask_pcnt", pulse_count, 0);
    check("mask_dcnt", drop_count, 0);
    force_req = 1'b1;
    step(1);
    force_req = 1'b0;
    exp_q.push_back(2'b11); exp_q.push_back(2'b11);
    exp_q.push_back(2'b11); exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
    drain_q("force_trig_busy");
    check("force_pcnt", pulse_count, 1);
    mask = 1'b0;

    // PULSE_WIDTH=1, HOLDOFF=0, request held high
    apply_reset();
    r2_req = 1'b1;
    step(3);
    step(1); check("r2_trig_e4", r2_trig, 1);
    step(1); check("r2_trig_e5", r2_trig, 0);
    step(1); check("r2_trig_e6", r2_trig, 1);
    step(1); check("r2_trig_e7", r2_trig, 0);
    check("r2_pcnt_e7", r2_pulse, 3);
    check("r2_dcnt_e7", r2_drop, 2);
    step(1);
    r2_clr = 1'b1;
    step(1);
    r2_clr = 1'b0;
    r2_req = 1'b0;
    check("r2_clr_pcnt", r2_pulse, 0);
    check("r2_clr_dcnt", r2_drop, 0);
    step(1);
    check("r2_trig_e10", r2_trig, 1);

    // reset mid-pulse truncates immediately and nothing resumes
    apply_reset();
    step(9);
    pulse_req();
    step(2);
    check("mid_trig_hi", trig_out, 1);
    #1;
    clr_n = 1'b0;
    #1;
    check("mid_trig_lo", trig_out, 0);
    check("mid_busy_lo", busy, 0);
    clr_n = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(2'b00);
    drain_q("mid_after_rel");
    check("mid_pcnt", pulse_count, 0);

    // FORCE held for 80000 edges: accepts every 13 edges, drops saturate
    apply_reset();
    step(2);
    force_req = 1'b1;
    step(80000);
    force_req = 1'b0;
    check("sat_dcnt", drop_count, 16'hFFFF);
    check("sat_pcnt", pulse_count, 16'd6154);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
